// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and baud helpers for the UART command decoder.
package uart_cmd_pkg;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_GOT, P_DISCARD} parse_state_t;
  typedef enum logic [2:0] {
    CMD_NONE, CMD_START, CMD_PAUSE, CMD_ENC, CMD_DEC, CMD_CLEAR, CMD_RESET
  } cmd_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_S_UC = 8'h53;
  localparam logic [7:0] ASCII_S_LC = 8'h73;
  localparam logic [7:0] ASCII_P_UC = 8'h50;
  localparam logic [7:0] ASCII_P_LC = 8'h70;
  localparam logic [7:0] ASCII_E_UC = 8'h45;
  localparam logic [7:0] ASCII_E_LC = 8'h65;
  localparam logic [7:0] ASCII_D_UC = 8'h44;
  localparam logic [7:0] ASCII_D_LC = 8'h64;
  localparam logic [7:0] ASCII_C_UC = 8'h43;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_R_UC = 8'h52;
  localparam logic [7:0] ASCII_R_LC = 8'h72;

  function automatic int baud_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int half_baud_cnt(input int clk_freq, input int uart_bps);
    return (clk_freq / uart_bps) / 2;
  endfunction

  function automatic logic is_terminator(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  // Case-insensitive letter lookup; anything unknown maps to CMD_NONE.
  function automatic cmd_t decode_letter(input logic [7:0] b);
    case (b)
      ASCII_S_UC, ASCII_S_LC: return CMD_START;
      ASCII_P_UC, ASCII_P_LC: return CMD_PAUSE;
      ASCII_E_UC, ASCII_E_LC: return CMD_ENC;
      ASCII_D_UC, ASCII_D_LC: return CMD_DEC;
      ASCII_C_UC, ASCII_C_LC: return CMD_CLEAR;
      ASCII_R_UC, ASCII_R_LC: return CMD_RESET;
      default:                return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 2-FF synchroniser plus 8N1 byte receiver with glitch rejection and
// framing-error detection; waits out a held-low line before rearming.
module uart_byte_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int BAUD_CNT = baud_cnt(CLK_FREQ, UART_BPS);
  localparam int HALF_CNT = half_baud_cnt(CLK_FREQ, UART_BPS);
  localparam int CW       = $clog2(BAUD_CNT + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  logic          rxd_meta;
  logic          rxd_sync;
  logic          rxd_prev;
  logic          fall;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Reset to idle-high so a reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign fall = rxd_prev & ~rxd_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        R_IDLE: begin
          cnt <= '0;
          if (fall) state <= R_START;
        end
        R_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_sync ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == BAUD_LAST) begin
            cnt     <= '0;
            shreg   <= {rxd_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= R_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == BAUD_LAST) begin
            cnt <= '0;
            if (rxd_sync) begin
              rx_data    <= shreg;
              byte_valid <= 1'b1;
              state      <= R_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= R_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_BREAK: begin
          if (rxd_sync) state <= R_IDLE;
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes single-letter ASCII command lines from the host UART into the
// work/enc run controls and a statistics-clear pulse.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int UART_BPS        = 115200,
  parameter int CMD_TIMEOUT_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       work,
  output logic       enc,
  output logic       clr_stats,
  output logic       cmd_valid,
  output logic       cmd_err,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid
);

  localparam int TW = $clog2(CMD_TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CMD_TIMEOUT_CYC - 1);

  logic [7:0]   rx_data;
  logic         byte_valid;
  logic         frame_err;
  logic         is_term;
  cmd_t         letter_cmd;
  cmd_t         pending;
  parse_state_t p_state;
  logic [TW-1:0] tmo_cnt;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign rx_byte       = rx_data;
  assign rx_byte_valid = byte_valid;
  assign is_term       = is_terminator(rx_data);
  assign letter_cmd    = decode_letter(rx_data);

  // Framing error outranks both bytes and the timeout, so only one cmd_err fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state   <= P_IDLE;
      pending   <= CMD_NONE;
      tmo_cnt   <= '0;
      work      <= 1'b0;
      enc       <= 1'b1;
      clr_stats <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      clr_stats <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (frame_err) begin
        cmd_err <= 1'b1;
        p_state <= P_IDLE;
        tmo_cnt <= '0;
      end else if (byte_valid) begin
        tmo_cnt <= '0;
        case (p_state)
          P_IDLE: begin
            if (!is_term) begin
              if (letter_cmd != CMD_NONE) begin
                pending <= letter_cmd;
                p_state <= P_GOT;
              end else begin
                p_state <= P_DISCARD;
              end
            end
          end
          P_GOT: begin
            if (is_term) begin
              cmd_valid <= 1'b1;
              p_state   <= P_IDLE;
              case (pending)
                CMD_START: work <= 1'b1;
                CMD_PAUSE: work <= 1'b0;
                CMD_ENC:   enc  <= 1'b1;
                CMD_DEC:   enc  <= 1'b0;
                CMD_CLEAR: clr_stats <= 1'b1;
                CMD_RESET: begin
                  work      <= 1'b0;
                  enc       <= 1'b1;
                  clr_stats <= 1'b1;
                end
                default: ;
              endcase
            end else begin
              p_state <= P_DISCARD;
            end
          end
          P_DISCARD: begin
            if (is_term) begin
              cmd_err <= 1'b1;
              p_state <= P_IDLE;
            end
          end
          default: p_state <= P_IDLE;
        endcase
      end else if (p_state != P_IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          cmd_err <= 1'b1;
          p_state <= P_IDLE;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed scenarios plus random
// command lines checked against a line-based reference model.
module tb_uart_cmd_decoder;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BAUD     = 10;
  localparam int TMO      = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic       work;
  logic       enc;
  logic       clr_stats;
  logic       cmd_valid;
  logic       cmd_err;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;

  int tests_run = 0;
  int tests_failed = 0;

  int cv_cnt = 0, clr_cnt = 0, err_cnt = 0, rbv_cnt = 0;
  int exp_cv = 0, exp_clr = 0, exp_err = 0, exp_rbv = 0;

  logic       model_work = 1'b0;
  logic       model_enc = 1'b1;
  logic [7:0] model_line[$];
  logic [7:0] sent_q[$];
  logic       prev_valid = 1'b0;

  logic [7:0] cmd_letters [6] = '{8'h53, 8'h50, 8'h45, 8'h44, 8'h43, 8'h52};

  uart_cmd_decoder #(
    .CLK_FREQ        (CLK_FREQ),
    .UART_BPS        (UART_BPS),
    .CMD_TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rxd      (uart_rxd),
    .work          (work),
    .enc           (enc),
    .clr_stats     (clr_stats),
    .cmd_valid     (cmd_valid),
    .cmd_err       (cmd_err),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] toUpper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
  endfunction

  // Reference: a line is collected until CR/LF; exactly one known letter executes.
  task automatic modelByte(input logic [7:0] b, output logic v, output logic c, output logic e);
    v = 1'b0; c = 1'b0; e = 1'b0;
    if (b == 8'h0D || b == 8'h0A) begin
      if (model_line.size() == 1) begin
        case (toUpper(model_line[0]))
          8'h53: begin model_work = 1'b1; v = 1'b1; end
          8'h50: begin model_work = 1'b0; v = 1'b1; end
          8'h45: begin model_enc = 1'b1; v = 1'b1; end
          8'h44: begin model_enc = 1'b0; v = 1'b1; end
          8'h43: begin c = 1'b1; v = 1'b1; end
          8'h52: begin model_work = 1'b0; model_enc = 1'b1; c = 1'b1; v = 1'b1; end
          default: e = 1'b1;
        endcase
      end else if (model_line.size() > 1) begin
        e = 1'b1;
      end
      model_line.delete();
    end else begin
      model_line.push_back(b);
    end
    exp_cv  += int'(v);
    exp_clr += int'(c);
    exp_err += int'(e);
  endtask

  task automatic modelAbort(input logic framing);
    if (framing || model_line.size() != 0) exp_err++;
    model_line.delete();
  endtask

  always @(negedge clk) begin : monitor
    logic v, c, e;
    logic [7:0] b;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      cv_cnt  += int'(cmd_valid);
      clr_cnt += int'(clr_stats);
      err_cnt += int'(cmd_err);
      rbv_cnt += int'(rx_byte_valid);
      if (prev_valid) begin
        checkOutput("byte_pending", sent_q.size() != 0, 1);
        if (sent_q.size() != 0) begin
          b = sent_q.pop_front();
          checkOutput("rx_byte", rx_byte, b);
          modelByte(b, v, c, e);
          checkOutput("cmd_valid_step", cmd_valid, v);
          checkOutput("clr_stats_step", clr_stats, c);
          checkOutput("cmd_err_step", cmd_err, e);
          checkOutput("work_step", work, model_work);
          checkOutput("enc_step", enc, model_enc);
        end
      end
      prev_valid = rx_byte_valid;
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int stop_len);
    if (stop_bit) begin
      sent_q.push_back(b);
      exp_rbv++;
    end
    uart_rxd = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(BAUD);
    end
    uart_rxd = stop_bit;
    tick(stop_len);
    uart_rxd = 1'b1;
    tick(2);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b1, BAUD);
  endtask

  task automatic checkTotals(input string tag);
    tick(3);
    checkOutput({tag, "_work"}, work, model_work);
    checkOutput({tag, "_enc"}, enc, model_enc);
    checkOutput({tag, "_cmd_valid_cnt"}, cv_cnt, exp_cv);
    checkOutput({tag, "_clr_cnt"}, clr_cnt, exp_clr);
    checkOutput({tag, "_err_cnt"}, err_cnt, exp_err);
    checkOutput({tag, "_rx_valid_cnt"}, rbv_cnt, exp_rbv);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int e0;
    int kind;
    int nbytes;
    logic [7:0] b;
    rst = 1'b1;
    uart_rxd = 1'b1;
    tick(5);
    checkOutput("rst_work", work, 0);
    checkOutput("rst_enc", enc, 1);
    checkOutput("rst_rx_byte", rx_byte, 8'h00);
    checkOutput("rst_pulses", {cmd_valid, cmd_err, clr_stats, rx_byte_valid}, 4'b0000);
    rst = 1'b0;
    tick(5);

    sendByte(8'h53); sendByte(8'h0D);
    checkTotals("t1");
    checkOutput("t1_rx_hold", rx_byte, 8'h0D);

    sendByte(8'h64); sendByte(8'h0D); sendByte(8'h0A);
    checkTotals("t2a");
    sendByte(8'h45); sendByte(8'h0D);
    checkTotals("t2b");

    sendByte(8'h43); sendByte(8'h0D);
    checkTotals("t3a");
    sendByte(8'h72); sendByte(8'h0A);
    checkTotals("t3b");

    sendByte(8'h53); sendByte(8'h58); sendByte(8'h0D);
    checkTotals("t4a");
    sendByte(8'h53); sendByte(8'h0D);
    checkTotals("t4b");

    applyStimulus(8'h53, 1'b0, 30);
    modelAbort(1'b1);
    tick(10);
    checkTotals("t5_frame");
    sendByte(8'h50); sendByte(8'h0D);
    checkTotals("t5_after");
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(30);
    checkTotals("t5_glitch");

    sendByte(8'h53);
    tick(3);
    e0 = err_cnt;
    tick(400);
    checkOutput("t6_tmo_early", err_cnt, e0);
    tick(150);
    modelAbort(1'b0);
    checkTotals("t6_tmo");
    sendByte(8'h0D);
    checkTotals("t6_cr");

    sendByte(8'h53); sendByte(8'h0D);
    sendByte(8'h44); sendByte(8'h0D);
    checkTotals("t6_pre_rst");
    uart_rxd = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = i[0];
      tick(BAUD);
    end
    uart_rxd = 1'b1;
    rst = 1'b1;
    tick(1);
    checkOutput("t6_rst_work", work, 0);
    checkOutput("t6_rst_enc", enc, 1);
    checkOutput("t6_rst_rx_byte", rx_byte, 8'h00);
    tick(1);
    rst = 1'b0;
    model_work = 1'b0;
    model_enc = 1'b1;
    model_line.delete();
    tick(20);
    sendByte(8'h53); sendByte(8'h0D);
    checkTotals("t6_post_rst");

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        b = cmd_letters[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 1) b = b | 8'h20;
        sendByte(b);
      end else if (kind == 2) begin
        nbytes = $urandom_range(1, 3);
        for (int k = 0; k < nbytes; k++) begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h0D || b == 8'h0A) b = 8'h58;
          sendByte(b);
          tick($urandom_range(0, 20));
        end
      end
      tick($urandom_range(0, 20));
      sendByte(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 2) == 0) sendByte(8'h0A);
      checkTotals("rand");
    end

    tick(10);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
